// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with ROB rename tags and commit forwarding
module reg_file_rename #(
    parameter int REG_COUNT     = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [31:0]              rs1_value,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    output logic [31:0]              rs2_value,
    input  logic                     commit_en,
    input  logic [REG_ID_BIT-1:0]    commit_reg,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [31:0]              commit_value,
    input  logic                     clear_all,
    output logic [31:0]              commit_count
);

    typedef struct packed {
        logic                     busy;
        logic [ROB_WIDTH_BIT-1:0] tag;
        logic [31:0]              value;
    } lookup_t;

    logic [31:0]              value_q [REG_COUNT];
    logic [ROB_WIDTH_BIT-1:0] tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0]     busy_q;
    lookup_t                  rs1_res;
    lookup_t                  rs2_res;

    logic commit_ok;
    logic issue_ok;

    assign commit_ok = commit_en && (commit_reg != '0);
    assign issue_ok  = issue_en && (issue_rd != '0) && !clear_all;

    // Issue assignments come after commit so a same-cycle issue owns busy/tag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q       <= '0;
            commit_count <= '0;
        end else if (rdy_in) begin
            if (commit_ok) begin
                value_q[commit_reg] <= commit_value;
                commit_count        <= commit_count + 32'd1;
                if (tag_q[commit_reg] == commit_rob_id) begin
                    busy_q[commit_reg] <= 1'b0;
                end
            end
            if (clear_all) begin
                busy_q <= '0;
            end else if (issue_ok) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_id;
            end
        end
    end

    function automatic lookup_t lookup(input logic [REG_ID_BIT-1:0] id);
        lookup_t r;
        r.busy  = busy_q[id];
        r.tag   = tag_q[id];
        r.value = value_q[id];
        if (id == '0) begin
            r.busy  = 1'b0;
            r.value = '0;
        end else if (commit_en && (commit_reg == id) && busy_q[id]
                     && (tag_q[id] == commit_rob_id)) begin
            r.busy  = 1'b0;
            r.value = commit_value;
        end
        return r;
    endfunction

    always_comb begin
        rs1_res = lookup(rs1_id);
        rs2_res = lookup(rs2_id);
    end

    assign rs1_busy  = rs1_res.busy;
    assign rs1_tag   = rs1_res.tag;
    assign rs1_value = rs1_res.value;
    assign rs2_busy  = rs2_res.busy;
    assign rs2_tag   = rs2_res.tag;
    assign rs2_value = rs2_res.value;

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - scoreboard bench for reg_file_rename
module tb_reg_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1_id, rs2_id;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_value, rs2_value;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        clear_all;
    logic [31:0] commit_count;

    reg_file_rename dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .clear_all(clear_all), .commit_count(commit_count)
    );

    always #5 clk_in = ~clk_in;

    // kind: 0 = rs1 port, 1 = rs2 port, 2 = commit_count
    typedef struct {
        int          kind;
        logic        busy;
        logic        chk_tag;
        logic [3:0]  tag;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_val  [32];
    logic [3:0]  m_tag  [32];
    logic        m_busy [32];
    logic [31:0] m_cnt;

    function automatic void push_exp(int kind, logic b, logic ct, logic [3:0] t,
                                     logic [31:0] v, string n);
        exp_t e;
        e.kind = kind; e.busy = b; e.chk_tag = ct; e.tag = t; e.val = v; e.name = n;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic rdy, input logic ien, input logic [4:0] ird,
                         input logic [3:0] irob, input logic cen, input logic [4:0] creg,
                         input logic [3:0] crob, input logic [31:0] cval, input logic clr,
                         input logic [4:0] r1, input logic [4:0] r2);
        rdy_in = rdy; issue_en = ien; issue_rd = ird; issue_rob_id = irob;
        commit_en = cen; commit_reg = creg; commit_rob_id = crob; commit_value = cval;
        clear_all = clr; rs1_id = r1; rs2_id = r2;
    endtask

    task automatic test_reset();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            case (c)
                0: drive(1, 1, 5, 3, 1, 5, 0, 32'hAA, 0, 0, 0);
                1: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
                    push_exp(0, 1, 1, 3, 32'hAA, "setup_x5");
                    push_exp(2, 0, 0, 0, 32'd1, "setup_count");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
                    #2 rst_in = 1'b0;
                    push_exp(0, 0, 1, 0, 32'h0, "reset_rs1");
                    push_exp(2, 0, 0, 0, 32'd0, "reset_count");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
            if (c == 2) #1 rst_in = 1'b1;
        end
    endtask

    task automatic test_issue_commit();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            case (c)
                0: drive(1, 1, 3, 7, 0, 0, 0, 0, 0, 0, 0);
                1: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
                    push_exp(0, 1, 1, 7, 32'h0, "issue_busy");
                end
                2: begin
                    drive(1, 0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 0, 3, 0);
                    push_exp(0, 0, 0, 0, 32'hDEADBEEF, "commit_forward");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
                    push_exp(0, 0, 1, 7, 32'hDEADBEEF, "commit_stored");
                    push_exp(2, 0, 0, 0, 32'd1, "commit_count_1");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
        end
    endtask

    task automatic test_stale_commit();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            case (c)
                0: drive(1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0);
                1: drive(1, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0);
                2: begin
                    drive(1, 0, 0, 0, 1, 4, 2, 32'h11, 0, 4, 0);
                    push_exp(0, 1, 1, 5, 32'h0, "stale_no_forward");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
                    push_exp(0, 1, 1, 5, 32'h11, "stale_stored");
                    push_exp(2, 0, 0, 0, 32'd2, "stale_count");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            case (c)
                0: drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
                1: begin
                    drive(1, 1, 6, 9, 1, 6, 1, 32'h22, 0, 6, 0);
                    push_exp(0, 0, 0, 0, 32'h22, "same_cycle_forward");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
                    push_exp(0, 1, 1, 9, 32'h22, "same_cycle_issue_wins");
                    push_exp(2, 0, 0, 0, 32'd3, "same_cycle_count");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
        end
    endtask

    task automatic test_flush();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            case (c)
                0: drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
                1: drive(1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0);
                2: begin
                    drive(1, 1, 3, 3, 0, 0, 0, 0, 0, 1, 2);
                    push_exp(0, 1, 1, 1, 32'h0, "pre_flush_x1");
                    push_exp(1, 1, 1, 2, 32'h0, "pre_flush_x2");
                end
                3: begin
                    drive(1, 1, 8, 4, 0, 0, 0, 0, 1, 3, 8);
                    push_exp(0, 1, 1, 3, 32'hDEADBEEF, "pre_flush_x3");
                    push_exp(1, 0, 1, 0, 32'h0, "pre_flush_x8");
                end
                4: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 8);
                    push_exp(0, 0, 1, 3, 32'hDEADBEEF, "flush_x3");
                    push_exp(1, 0, 1, 0, 32'h0, "flush_x8_issue_ignored");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
                    push_exp(0, 0, 1, 1, 32'h0, "flush_x1_tag_kept");
                    push_exp(1, 0, 1, 2, 32'h0, "flush_x2_tag_kept");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
        end
    endtask

    task automatic test_x0_stall();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            case (c)
                0: begin
                    drive(1, 1, 0, 5, 1, 0, 0, 32'h55, 0, 0, 0);
                    push_exp(0, 0, 0, 0, 32'h0, "x0_during_commit");
                end
                1: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    push_exp(0, 0, 0, 0, 32'h0, "x0_after_commit");
                    push_exp(2, 0, 0, 0, 32'd3, "x0_count_unchanged");
                end
                2: drive(0, 1, 10, 6, 1, 9, 0, 32'h99, 0, 9, 10);
                3: begin
                    drive(1, 1, 10, 6, 1, 9, 0, 32'h99, 0, 9, 10);
                    push_exp(0, 0, 0, 0, 32'h0, "stall_x9_held");
                    push_exp(1, 0, 0, 0, 32'h0, "stall_x10_held");
                    push_exp(2, 0, 0, 0, 32'd3, "stall_count_held");
                end
                default: begin
                    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
                    push_exp(0, 0, 0, 0, 32'h99, "resume_x9");
                    push_exp(1, 1, 1, 6, 32'h0, "resume_x10");
                    push_exp(2, 0, 0, 0, 32'd4, "resume_count");
                end
            endcase
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic gb; logic [3:0] gt; logic [31:0] gv;
        logic rdy, ien, cen, clr;
        logic [4:0] ird, creg, id;
        logic [3:0] irob, crob;
        logic [31:0] cval;
        @(negedge clk_in);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_in = 1'b0;
        #2 rst_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
        end
        m_cnt = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_in);
            rdy  = ($urandom_range(0, 9) != 0);
            ien  = $urandom_range(0, 1);
            ird  = 5'($urandom_range(0, 7));
            irob = 4'($urandom_range(0, 3));
            cen  = rdy && ($urandom_range(0, 2) != 0);
            creg = 5'($urandom_range(0, 7));
            crob = 4'($urandom_range(0, 3));
            cval = $urandom;
            clr  = ($urandom_range(0, 11) == 0);
            drive(rdy, ien, ird, irob, cen, creg, crob, cval, clr,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            for (int p = 0; p < 2; p++) begin
                id = (p == 0) ? rs1_id : rs2_id;
                if (id == 0)
                    push_exp(p, 0, 0, 0, 32'h0, "rand_x0");
                else if (cen && creg == id && m_busy[id] && m_tag[id] == crob)
                    push_exp(p, 0, 0, 0, cval, "rand_forward");
                else
                    push_exp(p, m_busy[id], 1, m_tag[id], m_val[id], "rand_stored");
            end
            push_exp(2, 0, 0, 0, m_cnt, "rand_count");
            #1;
            while (sb.size() != 0) begin
                e  = sb.pop_front();
                gb = (e.kind == 0) ? rs1_busy : (e.kind == 1) ? rs2_busy : 1'b0;
                gt = (e.kind == 0) ? rs1_tag : rs2_tag;
                gv = (e.kind == 0) ? rs1_value : (e.kind == 1) ? rs2_value : commit_count;
                vectors++;
                if (gb !== e.busy || (e.chk_tag && gt !== e.tag) || gv !== e.val) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: got busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                             e.name, c, gb, gt, gv, e.busy, e.tag, e.val);
                end
            end
            if (rdy) begin
                if (cen && creg != 0) begin
                    m_val[creg] = cval;
                    m_cnt = m_cnt + 1;
                    if (m_tag[creg] == crob) m_busy[creg] = 1'b0;
                end
                if (clr) begin
                    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                end else if (ien && ird != 0) begin
                    m_busy[ird] = 1'b1;
                    m_tag[ird]  = irob;
                end
            end
        end
    endtask

    initial begin
        rst_in = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_x0_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the ROB commit port and upstream of the decoder operand lookup.
- Holds committed values for x0..x31.
- Records which ROB entry will produce each register's next value (the "busy" and "tag" state).
- Gives the decoder/RS either a committed value or the ROB tag to wait on. Forwards same-cycle commits.

Parameters:
- REG_COUNT, 32, number of architectural registers (x0 hardwired to zero).
- REG_ID_BIT, 5, register index width.
- ROB_WIDTH_BIT, 4, ROB entry tag width.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, state holds and commit_count holds.
- issue_en  input  1  decoder issues an instruction that writes rd this cycle.
- issue_rd  input  REG_ID_BIT  destination register of the issued instruction.
- issue_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to the issued instruction.
- rs1_id  input  REG_ID_BIT  operand-1 lookup index.
- rs2_id  input  REG_ID_BIT  operand-2 lookup index.
- rs1_busy  output  1  operand 1 is pending in the ROB.
- rs1_tag  output  ROB_WIDTH_BIT  ROB tag for operand 1 (valid when rs1_busy=1).
- rs1_value  output  32  committed/forwarded value (valid when rs1_busy=0).
- rs2_busy, rs2_tag, rs2_value  outputs  same widths as the rs1 outputs  same meaning for operand 2.
- commit_en  input  1  ROB write-back strobe (ROB write_en).
- commit_reg  input  REG_ID_BIT  ROB reg_id.
- commit_rob_id  input  ROB_WIDTH_BIT  ROB rob_id of the committing entry.
- commit_value  input  32  ROB value_out.
- clear_all  input  1  ROB misprediction flush.
- commit_count  output  32  number of accepted commits to non-x0 registers, wraps at 2^32.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All values, busy bits and tags clear to 0.
  - commit_count clears to 0.
  - The combinational outputs therefore read busy=0, tag=0, value=0.
- Stall: with rdy_in=0, no state changes. Lookup outputs stay combinational from current state.
- Commit (commit_en=1, commit_reg!=0), at the clock edge:
  - value[commit_reg] <= commit_value.
  - commit_count increments.
  - busy[commit_reg] clears only if tag[commit_reg]==commit_rob_id. Otherwise a younger writer still owns the register, so busy and tag are kept.
- Issue (issue_en=1, issue_rd!=0, clear_all=0), at the clock edge: busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_id.
- Commit and issue to the same register in the same cycle:
  - The issue wins for busy/tag.
  - The commit value is still written.
- clear_all=1, at the clock edge:
  - All busy bits clear; tags are left unchanged.
  - An issue in the same cycle is ignored.
  - A commit in the same cycle still writes its value and counts.
- x0:
  - Always reads busy=0, value=0.
  - Writes, issues and commits to x0 are ignored; commit_count does not increment.
- Lookup, purely combinational, evaluated per port in this priority order:
  1. Index 0: busy=0, value=0.
  2. Forward: commit_en=1, commit_reg==rsN_id, and the stored busy=1 with tag==commit_rob_id. Output busy=0, value=commit_value.
  3. Otherwise: output the stored busy, tag and value.
- Lookups never see the same-cycle issue. The decoder resolves intra-group dependencies itself.
- No other latency: an issued register reads busy starting the cycle after issue_en.

Test Plan:
- Reset then lookup: rst_in pulsed low mid-cycle, rs1_id=5 -> rs1_busy=0, rs1_value=0, commit_count=0 without waiting for a clock edge.
- Issue then commit: issue rd=3, tag=7; next cycle rs1_id=3 -> busy=1, tag=7. Commit reg=3, rob=7, value=0xDEADBEEF -> same-cycle forward gives busy=0, value=0xDEADBEEF; after the edge the stored value is 0xDEADBEEF and commit_count=1.
- Stale commit: issue x4 tag 2, then issue x4 tag 5, then commit x4 rob 2 value 0x11 -> value=0x11 stored, busy stays 1, tag stays 5; the forward does not fire.
- Same-cycle issue and commit on x6: existing tag 1; commit rob 1 value 0x22 together with issue tag 9 -> value 0x22, busy=1, tag=9.
- Flush: x1, x2, x3 busy; assert clear_all together with issue x8 -> all busy=0 and x8 not busy next cycle.
- x0 and stall:
  - Commit x0 value 0x55 -> reads 0, count unchanged.
  - With rdy_in=0, commit x9 -> no update; updates after rdy_in returns high.
